// File: rtl/dec_secded_pipe.sv
// -----------------------------------------------------------------------------
// dec_secded_pipe
//
// Two-stage pipelined extended-Hamming (SECDED) decoder. One codeword per
// valid/ready handshake, in one of three widths selected per word by work_mod.
// Stage 1 masks the codeword to its mode width and computes the syndrome and
// overall parity. Stage 2 corrects a single-bit error, classifies the word and
// registers the right-aligned info bits. Two saturating event counters track
// corrected and uncorrectable words.
//
// Ports
//   clk            clock
//   rst            asynchronous active-low reset
//   in_valid       codeword valid
//   in_ready       decoder can accept (~out_valid | out_ready)
//   data_in        received codeword, mode-width bits right-aligned
//   work_mod       0: 8-bit, 1: 16-bit, 2: 32-bit codeword, other: invalid
//   out_valid      result valid
//   out_ready      consumer accepts result
//   data_out       corrected info bits, right-aligned, upper bits zero
//   num_of_errors  0 none, 1 corrected, 2 uncorrectable, 3 invalid mode
//   corr_cnt       corrected-word count, saturating
//   uncorr_cnt     uncorrectable-word count, saturating
//   clr_cnt        synchronous clear of both counters (wins over increment)
// -----------------------------------------------------------------------------
module dec_secded_pipe #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int AMBA_WORD          = 32,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  logic [AMBA_WORD-1:0]          work_mod,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic [1:0]                    num_of_errors,
    output logic [CNT_WIDTH-1:0]          corr_cnt,
    output logic [CNT_WIDTH-1:0]          uncorr_cnt,
    input  logic                          clr_cnt
);

    localparam logic [1:0] MODE_8   = 2'd0;
    localparam logic [1:0] MODE_16  = 2'd1;
    localparam logic [1:0] MODE_32  = 2'd2;
    localparam logic [1:0] MODE_BAD = 2'd3;

    localparam logic [1:0] CODE_NONE   = 2'd0;
    localparam logic [1:0] CODE_CORR   = 2'd1;
    localparam logic [1:0] CODE_UNCORR = 2'd2;
    localparam logic [1:0] CODE_BAD    = 2'd3;

    // Syndrome, first mask row in the MSB position. The code is linear, so the
    // column of bit j is simply the syndrome of a one-hot word at j.
    function automatic logic [4:0] calc_syn(input logic [31:0] cw, input logic [1:0] mode);
        logic [4:0] s;
        s = 5'd0;
        case (mode)
            MODE_8: begin
                s = {2'b00,
                     ^(cw & 32'h0000_00E4),
                     ^(cw & 32'h0000_00D2),
                     ^(cw & 32'h0000_00B1)};
            end
            MODE_16: begin
                s = {1'b0,
                     ^(cw & 32'h0000_FE08),
                     ^(cw & 32'h0000_F1C4),
                     ^(cw & 32'h0000_CDA2),
                     ^(cw & 32'h0000_AB61)};
            end
            MODE_32: begin
                s = {^(cw & 32'hFFFE_0010),
                     ^(cw & 32'hFF01_FC08),
                     ^(cw & 32'hF0F1_E384),
                     ^(cw & 32'hCCCD_9B42),
                     ^(cw & 32'hAAAB_56C1)};
            end
            default: s = 5'd0;
        endcase
        return s;
    endfunction

    function automatic int mode_width(input logic [1:0] mode);
        int w;
        w = 0;
        case (mode)
            MODE_8:  w = 8;
            MODE_16: w = 16;
            MODE_32: w = 32;
            default: w = 0;
        endcase
        return w;
    endfunction

    // Index of the overall-parity bit; it has no syndrome column.
    function automatic int par_index(input logic [1:0] mode);
        int p;
        p = 0;
        case (mode)
            MODE_8:  p = 3;
            MODE_16: p = 4;
            MODE_32: p = 5;
            default: p = 0;
        endcase
        return p;
    endfunction

    function automatic logic [31:0] extract_info(input logic [31:0] cw, input logic [1:0] mode);
        logic [31:0] info;
        info = 32'd0;
        case (mode)
            MODE_8:  info = {28'd0, cw[7:4]};
            MODE_16: info = {21'd0, cw[15:5]};
            MODE_32: info = {6'd0, cw[31:6]};
            default: info = 32'd0;
        endcase
        return info;
    endfunction

    logic adv;

    logic [1:0]  mode_in;
    logic [31:0] cw_in;

    logic        v1;
    logic [31:0] s1_cw;
    logic [1:0]  s1_mode;
    logic [4:0]  s1_syn;
    logic        s1_par;

    logic [31:0] cw_fixed;
    logic        col_hit;
    logic [31:0] dec_info;
    logic [1:0]  dec_code;

    // Whole pipeline moves together; a stalled result freezes both stages.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    always_comb begin
        mode_in = MODE_BAD;
        if (work_mod == AMBA_WORD'(0))
            mode_in = MODE_8;
        else if (work_mod == AMBA_WORD'(1))
            mode_in = MODE_16;
        else if (work_mod == AMBA_WORD'(2))
            mode_in = MODE_32;
    end

    always_comb begin
        cw_in = 32'd0;
        case (mode_in)
            MODE_8:  cw_in = {24'd0, data_in[7:0]};
            MODE_16: cw_in = {16'd0, data_in[15:0]};
            MODE_32: cw_in = data_in[31:0];
            default: cw_in = 32'd0;
        endcase
    end

    // Stage 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1      <= 1'b0;
            s1_cw   <= 32'd0;
            s1_mode <= MODE_8;
            s1_syn  <= 5'd0;
            s1_par  <= 1'b0;
        end else if (adv) begin
            v1 <= in_valid & in_ready;
            if (in_valid) begin
                s1_cw   <= cw_in;
                s1_mode <= mode_in;
                s1_syn  <= calc_syn(cw_in, mode_in);
                s1_par  <= ^cw_in;
            end
        end
    end

    // Single-error locate: flip the bit whose column matches the syndrome.
    // Columns are distinct and nonzero, so at most one bit flips.
    always_comb begin
        cw_fixed = s1_cw;
        col_hit  = 1'b0;
        for (int j = 0; j < 32; j++) begin
            if ((j < mode_width(s1_mode)) && (j != par_index(s1_mode)) &&
                (calc_syn(32'd1 << j, s1_mode) == s1_syn)) begin
                cw_fixed[j] = ~s1_cw[j];
                col_hit     = 1'b1;
            end
        end
    end

    always_comb begin
        dec_info = extract_info(s1_cw, s1_mode);
        dec_code = CODE_NONE;
        if (s1_mode == MODE_BAD) begin
            dec_info = 32'd0;
            dec_code = CODE_BAD;
        end else if (s1_syn == 5'd0) begin
            // Odd parity with a clean syndrome means only the parity bit flipped.
            dec_code = s1_par ? CODE_CORR : CODE_NONE;
        end else if (s1_par && col_hit) begin
            dec_info = extract_info(cw_fixed, s1_mode);
            dec_code = CODE_CORR;
        end else begin
            dec_code = CODE_UNCORR;
        end
    end

    // Stage 2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid     <= 1'b0;
            data_out      <= '0;
            num_of_errors <= CODE_NONE;
        end else if (adv) begin
            out_valid <= v1;
            if (v1) begin
                data_out      <= MAX_CODEWORD_WIDTH'(dec_info);
                num_of_errors <= dec_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            corr_cnt <= '0;
        end else if (clr_cnt) begin
            corr_cnt <= '0;
        end else if (adv && v1 && (dec_code == CODE_CORR) && (corr_cnt != '1)) begin
            corr_cnt <= corr_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uncorr_cnt <= '0;
        end else if (clr_cnt) begin
            uncorr_cnt <= '0;
        end else if (adv && v1 && (dec_code == CODE_UNCORR) && (uncorr_cnt != '1)) begin
            uncorr_cnt <= uncorr_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_dec_secded_pipe.sv
module tb_dec_secded_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic [31:0] work_mod;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic [1:0]  num_of_errors;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;
    logic        clr_cnt;

    int checks = 0;
    int errors = 0;

    dec_secded_pipe #(
        .MAX_CODEWORD_WIDTH(32),
        .AMBA_WORD(32),
        .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data_in(data_in),
        .work_mod(work_mod),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out(data_out),
        .num_of_errors(num_of_errors),
        .corr_cnt(corr_cnt),
        .uncorr_cnt(uncorr_cnt),
        .clr_cnt(clr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single word through an empty pipeline with out_ready high.
    task automatic send(input string tag, input logic [31:0] cw, input logic [31:0] mode,
                        input logic [31:0] exp_data, input logic [1:0] exp_code);
        int n;
        in_valid = 1'b1;
        data_in  = cw;
        work_mod = mode;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 5) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, data_out, exp_data);
        check({tag, "_code"}, 32'(num_of_errors), 32'(exp_code));
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        data_in   = 32'd0;
        work_mod  = 32'd0;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        repeat (3) tick();

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_code", 32'(num_of_errors), 32'd0);
        check("rst_corr", 32'(corr_cnt), 32'd0);
        check("rst_uncorr", 32'(uncorr_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        @(negedge clk);
        rst = 1'b1;
        tick();

        // Mode1 clean and single errors
        send("m1_clean", 32'h0000_00AA, 32'd0, 32'h0000_000A, 2'd0);
        check("m1_clean_corr", 32'(corr_cnt), 32'd0);
        send("m1_bit6", 32'h0000_00EA, 32'd0, 32'h0000_000A, 2'd1);
        check("m1_bit6_corr", 32'(corr_cnt), 32'd1);
        send("m1_par", 32'h0000_00A2, 32'd0, 32'h0000_000A, 2'd1);
        check("m1_par_corr", 32'(corr_cnt), 32'd2);
        send("m1_upper_masked", 32'hFFFF_FF55, 32'd0, 32'h0000_0005, 2'd0);

        // Mode1 double error
        send("m1_double", 32'h0000_00EB, 32'd0, 32'h0000_000E, 2'd2);
        check("m1_double_uncorr", 32'(uncorr_cnt), 32'd1);
        check("m1_double_corr", 32'(corr_cnt), 32'd2);

        // Mode3 and mode2
        send("m3_clean", 32'h0000_0000, 32'd2, 32'h0000_0000, 2'd0);
        send("m3_bit31", 32'h8000_0000, 32'd2, 32'h0000_0000, 2'd1);
        send("m2_bit5", 32'h0000_0020, 32'd1, 32'h0000_0000, 2'd1);
        check("m2_corr", 32'(corr_cnt), 32'd4);

        // Invalid mode
        send("bad_mode", 32'hFFFF_FFFF, 32'd3, 32'h0000_0000, 2'd3);
        check("bad_mode_corr", 32'(corr_cnt), 32'd4);
        check("bad_mode_uncorr", 32'(uncorr_cnt), 32'd1);

        // Backpressure: AA, EA, 55, EB
        tick();
        work_mod  = 32'd0;
        in_valid  = 1'b1;
        data_in   = 32'h0000_00AA;
        tick();
        data_in   = 32'h0000_00EA;
        tick();
        check("bp_first_valid", 32'(out_valid), 32'd1);
        check("bp_first_data", data_out, 32'h0000_000A);
        out_ready = 1'b0;
        data_in   = 32'h0000_0055;
        #1;
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", data_out, 32'h0000_000A);
            check("bp_hold_code", 32'(num_of_errors), 32'd0);
            check("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_w1_valid", 32'(out_valid), 32'd1);
        check("bp_w1_data", data_out, 32'h0000_000A);
        check("bp_w1_code", 32'(num_of_errors), 32'd1);
        data_in = 32'h0000_00EB;
        tick();
        in_valid = 1'b0;
        check("bp_w2_valid", 32'(out_valid), 32'd1);
        check("bp_w2_data", data_out, 32'h0000_0005);
        check("bp_w2_code", 32'(num_of_errors), 32'd0);
        tick();
        check("bp_w3_valid", 32'(out_valid), 32'd1);
        check("bp_w3_data", data_out, 32'h0000_000E);
        check("bp_w3_code", 32'(num_of_errors), 32'd2);
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_corr", 32'(corr_cnt), 32'd5);
        check("bp_uncorr", 32'(uncorr_cnt), 32'd2);

        // Clear, then drive corr_cnt to saturation
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr_corr", 32'(corr_cnt), 32'd0);
        check("clr_uncorr", 32'(uncorr_cnt), 32'd0);

        work_mod = 32'd0;
        data_in  = 32'h0000_00EA;
        in_valid = 1'b1;
        repeat (65534) tick();
        in_valid = 1'b0;
        repeat (2) tick();
        check("sat_fffe", 32'(corr_cnt), 32'h0000_FFFE);
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        repeat (2) tick();
        check("sat_ffff", 32'(corr_cnt), 32'h0000_FFFF);
        check("sat_uncorr", 32'(uncorr_cnt), 32'd0);

        // Clear in the same cycle as a counted correction
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        clr_cnt  = 1'b1;
        tick();
        clr_cnt  = 1'b0;
        check("clr_win_corr", 32'(corr_cnt), 32'd0);
        check("clr_win_valid", 32'(out_valid), 32'd1);
        check("clr_win_code", 32'(num_of_errors), 32'd1);
        tick();
        check("clr_win_after", 32'(corr_cnt), 32'd0);

        // Reset mid-stream
        in_valid = 1'b1;
        data_in  = 32'h0000_00EA;
        repeat (3) tick();
        check("pre_rst_corr", 32'(corr_cnt), 32'd2);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_corr", 32'(corr_cnt), 32'd0);
        check("mid_rst_data", data_out, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("post_rst_empty", 32'(out_valid), 32'd0);
        send("post_rst", 32'h0000_00AA, 32'd0, 32'h0000_000A, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
